note_sequencer: RTL and testbench

- Autoplay controller for the note-to-period lookup.
- Steps through a loadable song table of {note code, duration in beats} entries and drives the 4-bit note code into the lookup.
- Inserts a short silent gap between notes and supports start, stop, pause and loop.
- Arbitrates between autoplay and the live keypad; the live key always wins.

---
 rtl/note_sequencer.sv | 132 +++++++++++++
 tb/tb_note_sequencer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// note_sequencer: autoplays a loadable {note, beats} song table into the period lookup,
// with note gaps, pause/loop control and live-keypad override.
module note_sequencer #(
  parameter int BEAT_CYCLES = 10_000_000,
  parameter int GAP_CYCLES  = 400_000,
  parameter int ADDR_W      = 5,
  parameter int DUR_W       = 28
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop,
  input  logic              key_valid,
  input  logic [3:0]        key_note,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic [3:0]        note_code,
  output logic              busy,
  output logic              paused,
  output logic              key_active,
  output logic [ADDR_W-1:0] step_idx,
  output logic              song_done
);
  typedef enum logic [2:0] {IDLE, FETCH, NOTE, GAP, PAUSED} state_t;
  localparam logic [DUR_W-1:0] BEAT_W = DUR_W'(BEAT_CYCLES);
  localparam logic [DUR_W-1:0] GAP_W  = DUR_W'(GAP_CYCLES);
  state_t r_state, r_saved, w_state, w_saved;
  logic [DUR_W-1:0]  r_cnt, w_cnt;
  logic [ADDR_W-1:0] r_idx, w_idx;
  logic [3:0]        r_code, w_code, w_auto;
  logic [7:0]        r_mem [2**ADDR_W];
  logic [7:0]        r_rd;
  logic              w_adv, w_end, w_done;
  assign step_idx = r_idx;
  always_comb begin
    w_state = r_state;
    w_saved = r_saved;
    w_cnt   = r_cnt;
    w_idx   = r_idx;
    w_code  = r_code;
    w_adv   = 1'b0;
    w_end   = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      FETCH: begin
        if (r_rd[3:0] == 4'd0) w_end = 1'b1;
        else begin
          w_code  = r_rd[7:4];
          w_cnt   = DUR_W'(r_rd[3:0]) * BEAT_W - GAP_W;
          w_state = NOTE;
        end
      end
      NOTE: begin
        w_cnt = r_cnt - 1'b1;
        if (r_cnt == DUR_W'(1)) begin
          if (GAP_CYCLES == 0) w_adv = 1'b1;
          else begin
            w_state = GAP;
            w_cnt   = GAP_W;
          end
        end
      end
      GAP: begin
        w_cnt = r_cnt - 1'b1;
        if (r_cnt == DUR_W'(1)) w_adv = 1'b1;
      end
      PAUSED: if (pause) w_state = r_saved;
      default: ;
    endcase
    // running off the last table slot ends the song just like a zero-beat marker
    if (w_adv) begin
      if (r_idx == '1) w_end = 1'b1;
      else begin
        w_idx   = r_idx + 1'b1;
        w_state = FETCH;
      end
    end
    if (w_end) begin
      w_done  = 1'b1;
      w_idx   = loop ? '0 : r_idx;
      w_state = loop ? FETCH : IDLE;
    end
    // a pause only lands while the step keeps playing; the final cycle of a step ignores it
    if (pause && (r_state == NOTE || r_state == GAP) && (w_state == NOTE || w_state == GAP)) begin
      w_saved = w_state;
      w_state = PAUSED;
    end
    if (start) begin
      w_state = FETCH;
      w_idx   = '0;
      w_done  = 1'b0;
    end
    if (stop) begin
      w_state = IDLE;
      w_idx   = '0;
      w_done  = 1'b0;
    end
    w_auto = (w_state == NOTE) ? w_code : 4'd0;
  end
  always_ff @(posedge clk) begin
    if (wr_en && r_state == IDLE) r_mem[wr_addr] <= wr_data;
    r_rd <= r_mem[w_idx];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_saved    <= NOTE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_code     <= '0;
      note_code  <= '0;
      busy       <= 1'b0;
      paused     <= 1'b0;
      key_active <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_saved    <= w_saved;
      r_cnt      <= w_cnt;
      r_idx      <= w_idx;
      r_code     <= w_code;
      note_code  <= key_valid ? key_note : w_auto;
      busy       <= w_state != IDLE;
      paused     <= w_state == PAUSED;
      key_active <= key_valid;
      song_done  <= w_done;
    end
  end
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed scenarios plus random control traffic, checked every cycle
// against a step/elapsed-time model of the song player.
module tb_note_sequencer;
  localparam int B = 8, G = 2, AW = 3;
  logic clk = 0, rst_n = 0, start = 0, stop = 0, pause = 0, loop = 0, key_valid = 0, wr_en = 0;
  logic [3:0] key_note = 0;
  logic [AW-1:0] wr_addr = 0;
  logic [7:0] wr_data = 0;
  logic [3:0] note_code;
  logic busy, paused, key_active, song_done;
  logic [AW-1:0] step_idx;

  note_sequencer #(.BEAT_CYCLES(B), .GAP_CYCLES(G), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause), .loop(loop),
    .key_valid(key_valid), .key_note(key_note), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .note_code(note_code), .busy(busy), .paused(paused),
    .key_active(key_active), .step_idx(step_idx), .song_done(song_done));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [7:0] m_tab [8];
  bit m_active = 0, m_paused = 0, e_done = 0, e_key = 0;
  int m_idx = 0, m_el = 0;
  logic [3:0] e_note = 0;
  int c3 = 0, c5 = 0, cd = 0;

  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", n, a, e, $time);
    end
  endtask

  // elapsed cycles within a step: 0 = fetch, 1..beats*B-G = sounding, then the gap
  function automatic logic [3:0] auto_note();
    int b;
    b = int'(m_tab[m_idx][3:0]);
    if (m_active && !m_paused && m_el >= 1 && m_el <= b * B - G) return m_tab[m_idx][7:4];
    return 4'd0;
  endfunction

  task automatic model_step();
    int b;
    e_done = 0;
    if (wr_en && !m_active) m_tab[wr_addr] = wr_data;
    if (stop) begin
      m_active = 0; m_paused = 0; m_idx = 0;
    end else if (start) begin
      m_active = 1; m_paused = 0; m_idx = 0; m_el = 0;
    end else if (m_active && m_paused) begin
      if (pause) m_paused = 0;
    end else if (m_active) begin
      b = int'(m_tab[m_idx][3:0]);
      if ((m_el == 0 && b == 0) || (m_el != 0 && m_el == b * B && m_idx == 7)) begin
        e_done = 1;
        if (loop) begin m_idx = 0; m_el = 0; end
        else m_active = 0;
      end else if (m_el != 0 && m_el == b * B) begin
        m_idx++; m_el = 0;
      end else begin
        m_el++;
        if (pause && m_el > 1) m_paused = 1;
      end
    end
    e_note = key_valid ? key_note : auto_note();
    e_key = key_valid;
  endtask

  task automatic compare();
    chk("note_code", note_code, e_note);
    chk("busy", busy, m_active);
    chk("paused", paused, m_paused);
    chk("step_idx", step_idx, m_idx);
    chk("song_done", song_done, e_done);
    chk("key_active", key_active, e_key);
    if (note_code == 3) c3++;
    if (note_code == 5) c5++;
    if (song_done) cd++;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    compare();
    start = 0; stop = 0; pause = 0; wr_en = 0;
  endtask

  task automatic run(int n);
    repeat (n) cyc();
  endtask

  task automatic wr(int a, int d);
    wr_en = 1; wr_addr = AW'(a); wr_data = 8'(d);
    cyc();
  endtask

  task automatic chk_reset(string n);
    chk({n, "_note"}, note_code, 0);
    chk({n, "_busy"}, busy, 0);
    chk({n, "_paused"}, paused, 0);
    chk({n, "_key"}, key_active, 0);
    chk({n, "_idx"}, step_idx, 0);
    chk({n, "_done"}, song_done, 0);
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1 chk_reset("async_rst");
    m_active = 0; m_paused = 0; m_idx = 0; m_el = 0;
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic clr();
    c3 = 0; c5 = 0; cd = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 chk_reset("init");
    rst_n = 1;
    wr(0, 8'h32); wr(1, 8'h51); wr(2, 8'h00);
    for (int i = 3; i < 8; i++) wr(i, 8'h71);
    run(2);

    // plain playback
    clr(); start = 1; cyc();
    chk("t1_fetch_note", note_code, 0);
    cyc();
    chk("t1_latency", note_code, 3);
    run(33);
    chk("t1_n3", c3, 14); chk("t1_n5", c5, 6); chk("t1_done", cd, 1); chk("t1_busy", busy, 0);

    // looping
    clr(); loop = 1; start = 1; cyc(); run(59);
    chk("t2_done", cd, 2); chk("t2_busy", busy, 1);
    stop = 1; cyc(); loop = 0; run(2);

    // pause mid-note
    clr(); start = 1; cyc(); run(4);
    pause = 1; cyc();
    chk("t3_paused_note", note_code, 0); chk("t3_paused", paused, 1);
    run(19); pause = 1; cyc(); run(30);
    chk("t3_n3", c3, 14);

    // keypad override
    clr(); start = 1; cyc(); run(18);
    key_valid = 1; key_note = 4'hC; cyc();
    chk("t4_key_note", note_code, 12); chk("t4_key_active", key_active, 1);
    run(2); key_valid = 0; cyc(); run(10);
    chk("t4_n5", c5, 3);

    // stop and write-while-playing
    clr(); start = 1; cyc(); run(5);
    wr(0, 8'h77); stop = 1; cyc();
    chk("t5_busy", busy, 0); chk("t5_idx", step_idx, 0); chk("t5_note", note_code, 0);
    run(2); chk("t5_done", cd, 0);
    start = 1; cyc(); cyc();
    chk("t5_table_kept", note_code, 3);
    stop = 1; cyc(); run(2);

    // full table, wrap at index 7, reset mid-note
    for (int i = 0; i < 8; i++) wr(i, {4'(i + 1), 4'd1});
    clr(); start = 1; cyc(); run(79);
    chk("t6_done", cd, 1); chk("t6_idx", step_idx, 7);
    start = 1; cyc(); run(5);
    do_reset();
    clr(); start = 1; cyc(); run(79);
    chk("t6_done_after_rst", cd, 1);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      stop = ($urandom % 100) == 0;
      start = ($urandom % 40) == 0;
      pause = ($urandom % 15) == 0;
      wr_en = !start && ($urandom % 6) == 0;
      wr_addr = AW'($urandom);
      wr_data = {4'($urandom), 4'($urandom_range(0, 3))};
      if ($urandom % 50 == 0) loop = ~loop;
      key_valid = ($urandom % 10) == 0;
      key_note = 4'($urandom);
      if ($urandom % 900 == 0) begin
        start = 0; stop = 0; pause = 0; wr_en = 0;
        do_reset();
      end else cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
